// File: rtl/cmac_core_actv_feeder.sv
// rtl/cmac_core_actv_feeder.sv - CMAC activation feeder: double-buffered weights paired with data beats into the MAC.
// Optional macro CMAC_FEEDER_ZERO_GATE_EN zeroes lanes whose data or weight mask is clear.
module cmac_core_actv_feeder #(
    parameter int ATOMC = 8,
    parameter int BPE   = 8,
    parameter int CNT_W = 16
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   cfg_reg_en,
    input  logic                   in_wt_pvld,
    output logic                   in_wt_prdy,
    input  logic [ATOMC*BPE-1:0]   in_wt_data,
    input  logic [ATOMC-1:0]       in_wt_mask,
    input  logic                   in_dat_pvld,
    output logic                   in_dat_prdy,
    input  logic [ATOMC*BPE-1:0]   in_dat_data,
    input  logic [ATOMC-1:0]       in_dat_mask,
    input  logic                   in_dat_stripe_st,
    input  logic                   in_dat_stripe_end,
    output logic [ATOMC*BPE-1:0]   dat_actv_data,
    output logic [ATOMC-1:0]       dat_actv_nz,
    output logic [ATOMC-1:0]       dat_actv_pvld,
    output logic [ATOMC*BPE-1:0]   wt_actv_data,
    output logic [ATOMC-1:0]       wt_actv_nz,
    output logic [ATOMC-1:0]       wt_actv_pvld,
    output logic [CNT_W-1:0]       stripe_beat_cnt,
    output logic                   proto_err
);
    localparam int DW = ATOMC * BPE;

    typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      shadow_data_q, shadow_data_d, active_data_q, active_data_d;
    logic [ATOMC-1:0]   shadow_mask_q, shadow_mask_d, active_mask_q, active_mask_d;
    logic               shadow_vld_q, shadow_vld_d;
    logic               proto_err_q, proto_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      dat_out_q, dat_out_d, wt_out_q, wt_out_d;
    logic [ATOMC-1:0]   dat_nz_q, dat_nz_d, wt_nz_q, wt_nz_d;
    logic               pvld_q, pvld_d;

    logic               wt_acc, dat_acc, swap;
    logic [DW-1:0]      cur_wt_data, gated_dat, gated_wt;
    logic [ATOMC-1:0]   cur_wt_mask, dnz, wnz;

    always_comb begin
        in_dat_prdy = !cfg_reg_en && (in_dat_stripe_st ? shadow_vld_q : (state_q == ACTIVE));
        dat_acc     = in_dat_pvld && in_dat_prdy;
        swap        = dat_acc && in_dat_stripe_st;
        in_wt_prdy  = !cfg_reg_en && (!shadow_vld_q || swap);
        wt_acc      = in_wt_pvld && in_wt_prdy;
        // The beat is paired with the weight that is active after this cycle's swap.
        cur_wt_data = swap ? shadow_data_q : active_data_q;
        cur_wt_mask = swap ? shadow_mask_q : active_mask_q;
    end

    always_comb begin
        gated_dat = in_dat_data;
        gated_wt  = cur_wt_data;
`ifdef CMAC_FEEDER_ZERO_GATE_EN
        dnz = in_dat_mask & cur_wt_mask;
        wnz = in_dat_mask & cur_wt_mask;
        for (int i = 0; i < ATOMC; i++) begin
            if (!dnz[i]) begin
                gated_dat[i*BPE +: BPE] = '0;
                gated_wt[i*BPE +: BPE]  = '0;
            end
        end
`else
        dnz = in_dat_mask;
        wnz = cur_wt_mask;
`endif
    end

    always_comb begin
        state_d       = state_q;
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        shadow_vld_d  = shadow_vld_q;
        active_data_d = active_data_q;
        active_mask_d = active_mask_q;
        proto_err_d   = proto_err_q;
        cnt_d         = cnt_q;
        dat_out_d     = dat_out_q;
        wt_out_d      = wt_out_q;
        dat_nz_d      = dat_nz_q;
        wt_nz_d       = wt_nz_q;
        pvld_d        = 1'b0;

        if (cfg_reg_en) begin
            state_d      = EMPTY;
            shadow_vld_d = 1'b0;
            proto_err_d  = 1'b0;
            cnt_d        = '0;
        end else begin
            if (swap) begin
                active_data_d = shadow_data_q;
                active_mask_d = shadow_mask_q;
                shadow_vld_d  = 1'b0;
            end
            // A load in the swap cycle refills the shadow that was just promoted.
            if (wt_acc) begin
                shadow_data_d = in_wt_data;
                shadow_mask_d = in_wt_mask;
                shadow_vld_d  = 1'b1;
            end
            if ((state_q == EMPTY && in_dat_pvld && !in_dat_stripe_st) ||
                (state_q == ACTIVE && swap))
                proto_err_d = 1'b1;
            if (dat_acc) begin
                state_d   = in_dat_stripe_end ? EMPTY : ACTIVE;
                pvld_d    = 1'b1;
                dat_out_d = gated_dat;
                wt_out_d  = gated_wt;
                dat_nz_d  = dnz;
                wt_nz_d   = wnz;
                if (in_dat_stripe_st)
                    cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                else if (cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q       <= EMPTY;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
            shadow_vld_q  <= 1'b0;
            active_data_q <= '0;
            active_mask_q <= '0;
            proto_err_q   <= 1'b0;
            cnt_q         <= '0;
            dat_out_q     <= '0;
            wt_out_q      <= '0;
            dat_nz_q      <= '0;
            wt_nz_q       <= '0;
            pvld_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            shadow_vld_q  <= shadow_vld_d;
            active_data_q <= active_data_d;
            active_mask_q <= active_mask_d;
            proto_err_q   <= proto_err_d;
            cnt_q         <= cnt_d;
            dat_out_q     <= dat_out_d;
            wt_out_q      <= wt_out_d;
            dat_nz_q      <= dat_nz_d;
            wt_nz_q       <= wt_nz_d;
            pvld_q        <= pvld_d;
        end
    end

    assign dat_actv_data   = dat_out_q;
    assign dat_actv_nz     = dat_nz_q;
    assign dat_actv_pvld   = {ATOMC{pvld_q}};
    assign wt_actv_data    = wt_out_q;
    assign wt_actv_nz      = wt_nz_q;
    assign wt_actv_pvld    = {ATOMC{pvld_q}};
    assign stripe_beat_cnt = cnt_q;
    assign proto_err       = proto_err_q;
endmodule

// File: tb/tb_cmac_core_actv_feeder.sv
// tb/tb_cmac_core_actv_feeder.sv - scoreboard bench for cmac_core_actv_feeder.
module tb_cmac_core_actv_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_reg_en = 1'b0;
    logic        in_wt_pvld = 1'b0, in_wt_prdy;
    logic [63:0] in_wt_data = '0;
    logic [7:0]  in_wt_mask = '0;
    logic        in_dat_pvld = 1'b0, in_dat_prdy;
    logic [63:0] in_dat_data = '0;
    logic [7:0]  in_dat_mask = '0;
    logic        in_dat_stripe_st = 1'b0, in_dat_stripe_end = 1'b0;
    logic [63:0] dat_actv_data, wt_actv_data;
    logic [7:0]  dat_actv_nz, dat_actv_pvld, wt_actv_nz, wt_actv_pvld;
    logic [15:0] stripe_beat_cnt;
    logic        proto_err;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [63:0] dat;
        logic [63:0] wt;
        logic [7:0]  dnz;
        logic [7:0]  wnz;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    cmac_core_actv_feeder dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .cfg_reg_en(cfg_reg_en),
        .in_wt_pvld(in_wt_pvld), .in_wt_prdy(in_wt_prdy), .in_wt_data(in_wt_data), .in_wt_mask(in_wt_mask),
        .in_dat_pvld(in_dat_pvld), .in_dat_prdy(in_dat_prdy), .in_dat_data(in_dat_data), .in_dat_mask(in_dat_mask),
        .in_dat_stripe_st(in_dat_stripe_st), .in_dat_stripe_end(in_dat_stripe_end),
        .dat_actv_data(dat_actv_data), .dat_actv_nz(dat_actv_nz), .dat_actv_pvld(dat_actv_pvld),
        .wt_actv_data(wt_actv_data), .wt_actv_nz(wt_actv_nz), .wt_actv_pvld(wt_actv_pvld),
        .stripe_beat_cnt(stripe_beat_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every issued beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && (dat_actv_pvld !== 8'h00 || wt_actv_pvld !== 8'h00)) begin
            chk("wt_pvld", {56'h0, wt_actv_pvld}, 64'hFF);
            chk("dat_pvld", {56'h0, dat_actv_pvld}, 64'hFF);
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'h1, 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dat_data", dat_actv_data, e.dat);
                chk("wt_data", wt_actv_data, e.wt);
                chk("dat_nz", {56'h0, dat_actv_nz}, {56'h0, e.dnz});
                chk("wt_nz", {56'h0, wt_actv_nz}, {56'h0, e.wnz});
                chk("beat_cnt", {48'h0, stripe_beat_cnt}, {48'h0, e.cnt});
            end
        end
    end

    task automatic wt_load(input logic [63:0] d, input logic [7:0] m);
        bit done = 0;
        in_wt_pvld = 1'b1; in_wt_data = d; in_wt_mask = m;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_wt_prdy) done = 1;
            @(posedge clk); #1;
        end
        in_wt_pvld = 1'b0;
        if (!done) chk("wt_load_timeout", 64'h1, 64'h0);
    endtask

    task automatic dat_send(input logic [63:0] d, input logic [7:0] m, input logic st, input logic en,
                            input logic [63:0] ed, input logic [63:0] ew, input logic [7:0] ednz,
                            input logic [7:0] ewnz, input logic [15:0] ecnt);
        bit done = 0;
        in_dat_pvld = 1'b1; in_dat_data = d; in_dat_mask = m;
        in_dat_stripe_st = st; in_dat_stripe_end = en;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_dat_prdy) begin
                sb.push_back('{ed, ew, ednz, ewnz, ecnt});
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_dat_pvld = 1'b0; in_dat_stripe_st = 1'b0; in_dat_stripe_end = 1'b0;
        if (!done) chk("dat_send_timeout", 64'h1, 64'h0);
    endtask

    localparam logic [63:0] W0 = 64'h0807060504030201;
    localparam logic [63:0] WA = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] WB = 64'hB4B4B4B4B4B4B4B4;
    localparam logic [63:0] WC = 64'hC3C3C3C3C3C3C3C3;
    localparam logic [63:0] WD = 64'hD2D2D2D2D2D2D2D2;
    localparam logic [63:0] WE = 64'hF8F7F6F5F4F3F2F1;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_dat_pvld", {56'h0, dat_actv_pvld}, 64'h0);
        chk("rst_dat_data", dat_actv_data, 64'h0);
        chk("rst_cnt", {48'h0, stripe_beat_cnt}, 64'h0);
        chk("rst_proto_err", {63'h0, proto_err}, 64'h0);
        chk("rst_wt_prdy", {63'h0, in_wt_prdy}, 64'h1);
        chk("rst_dat_prdy", {63'h0, in_dat_prdy}, 64'h0);
        @(posedge clk); #1;

        // One-beat stripe
        wt_load(W0, 8'hFF);
        dat_send(64'h0101010101010101, 8'hFF, 1, 1, 64'h0101010101010101, W0, 8'hFF, 8'hFF, 16'd1);
        @(negedge clk);
        chk("t1_empty_prdy", {63'h0, in_dat_prdy}, 64'h0);
        @(negedge clk);
        chk("t1_cnt_hold", {48'h0, stripe_beat_cnt}, 64'd1);
        chk("t1_pvld_idle", {56'h0, dat_actv_pvld}, 64'h0);
        @(posedge clk); #1;

        // Stripe start waits for a weight
        in_dat_pvld = 1'b1; in_dat_data = 64'h0202020202020202; in_dat_mask = 8'hFF;
        in_dat_stripe_st = 1'b1; in_dat_stripe_end = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_dat_stall", {63'h0, in_dat_prdy}, 64'h0);
            @(posedge clk); #1;
        end
        wt_load(WA, 8'hFF);
        dat_send(64'h0202020202020202, 8'hFF, 1, 1, 64'h0202020202020202, WA, 8'hFF, 8'hFF, 16'd1);
        chk("t2_no_err", {63'h0, proto_err}, 64'h0);

        // 4-beat stripe on WB while WC loads behind it
        wt_load(WB, 8'hFF);
        fork
            begin
                dat_send(64'h11, 8'hFF, 1, 0, 64'h11, WB, 8'hFF, 8'hFF, 16'd1);
                dat_send(64'h12, 8'hFF, 0, 0, 64'h12, WB, 8'hFF, 8'hFF, 16'd2);
                dat_send(64'h13, 8'hFF, 0, 0, 64'h13, WB, 8'hFF, 8'hFF, 16'd3);
                dat_send(64'h14, 8'hFF, 0, 1, 64'h14, WB, 8'hFF, 8'hFF, 16'd4);
            end
            wt_load(WC, 8'hFF);
        join
        @(negedge clk);
        chk("t3_cnt4", {48'h0, stripe_beat_cnt}, 64'd4);
        @(posedge clk); #1;
        dat_send(64'h15, 8'hFF, 1, 1, 64'h15, WC, 8'hFF, 8'hFF, 16'd1);

        // Same-cycle swap and load
        wt_load(WA, 8'hFF);
        in_dat_pvld = 1'b1; in_dat_data = 64'h21; in_dat_mask = 8'hFF;
        in_dat_stripe_st = 1'b1; in_dat_stripe_end = 1'b0;
        in_wt_pvld = 1'b1; in_wt_data = WD; in_wt_mask = 8'hFF;
        @(negedge clk);
        chk("t4_wt_prdy", {63'h0, in_wt_prdy}, 64'h1);
        chk("t4_dat_prdy", {63'h0, in_dat_prdy}, 64'h1);
        if (in_dat_prdy) sb.push_back('{64'h21, WA, 8'hFF, 8'hFF, 16'd1});
        @(posedge clk); #1;
        in_dat_pvld = 1'b0; in_wt_pvld = 1'b0; in_dat_stripe_st = 1'b0;

        // Restart inside an open stripe
        @(negedge clk);
        chk("t5_err_before", {63'h0, proto_err}, 64'h0);
        @(posedge clk); #1;
        dat_send(64'h22, 8'hFF, 1, 0, 64'h22, WD, 8'hFF, 8'hFF, 16'd1);
        @(negedge clk);
        chk("t5_err_set", {63'h0, proto_err}, 64'h1);
        @(posedge clk); #1;

        // Flush overrides accepts
        cfg_reg_en = 1'b1;
        in_dat_pvld = 1'b1; in_dat_data = 64'h23; in_dat_stripe_st = 1'b0;
        in_wt_pvld = 1'b1; in_wt_data = WB;
        @(negedge clk);
        chk("t5_cfg_wt_prdy", {63'h0, in_wt_prdy}, 64'h0);
        chk("t5_cfg_dat_prdy", {63'h0, in_dat_prdy}, 64'h0);
        @(posedge clk); #1;
        cfg_reg_en = 1'b0; in_dat_pvld = 1'b0; in_wt_pvld = 1'b0;
        @(negedge clk);
        chk("t5_err_clr", {63'h0, proto_err}, 64'h0);
        chk("t5_pvld0", {56'h0, dat_actv_pvld}, 64'h0);
        chk("t5_cnt0", {48'h0, stripe_beat_cnt}, 64'h0);
        chk("t5_flush_dat_prdy", {63'h0, in_dat_prdy}, 64'h0);
        chk("t5_flush_wt_prdy", {63'h0, in_wt_prdy}, 64'h1);
        @(posedge clk); #1;

        // Mask handling
        wt_load(WE, 8'h3C);
`ifdef CMAC_FEEDER_ZERO_GATE_EN
        dat_send(64'h8877665544332211, 8'hF0, 1, 1, 64'h0000665500000000, 64'h0000F6F500000000,
                 8'h30, 8'h30, 16'd1);
`else
        dat_send(64'h8877665544332211, 8'hF0, 1, 1, 64'h8877665544332211, WE, 8'hF0, 8'h3C, 16'd1);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", {32'h0, sb.size()}, 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cmac_core_actv_feeder.md
Name: cmac_core_actv_feeder

Overview:
- Transmit side of the CMAC activation interface: drives dat_actv_*/wt_actv_* into the 8-lane MAC cell, which has no backpressure.
- Weights are double-buffered (shadow/active). Data beats are paired with the active weight and issued one beat per cycle, with registered outputs.
- Sits between the sequencer-side weight/data streams and the MAC array in the CMAC core.

Parameters:
- ATOMC, 8, lanes per beat; must match the MAC lane count.
- BPE, 8, bits per element.
- CNT_W, 16, width of the per-stripe beat counter.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  asynchronous, active-high reset.
- cfg_reg_en  in  1  operation start pulse; flushes both weight buffers.
- in_wt_pvld  in  1  weight beat valid.
- in_wt_prdy  out  1  weight beat ready.
- in_wt_data  in  ATOMC*BPE  weight elements, lane i in bits [i*BPE +: BPE].
- in_wt_mask  in  ATOMC  weight nonzero mask.
- in_dat_pvld  in  1  data beat valid.
- in_dat_prdy  out  1  data beat ready.
- in_dat_data  in  ATOMC*BPE  data elements.
- in_dat_mask  in  ATOMC  data nonzero mask.
- in_dat_stripe_st  in  1  first beat of a stripe.
- in_dat_stripe_end  in  1  last beat of a stripe.
- dat_actv_data  out  ATOMC*BPE  data to MAC.
- dat_actv_nz  out  ATOMC  data nonzero flags to MAC.
- dat_actv_pvld  out  ATOMC  per-lane valid to MAC.
- wt_actv_data  out  ATOMC*BPE  weight to MAC.
- wt_actv_nz  out  ATOMC  weight nonzero flags to MAC.
- wt_actv_pvld  out  ATOMC  per-lane valid to MAC.
- stripe_beat_cnt  out  CNT_W  beats issued in the current stripe.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, active-high): all outputs 0, shadow_vld=0, active_vld=0, FSM=EMPTY, proto_err=0.
- Buffers:
  - shadow (data, mask, shadow_vld) and active (data, mask, active_vld).
  - Weight accept: in_wt_pvld & in_wt_prdy.
  - in_wt_prdy = !shadow_vld | swap, where swap = data accept with stripe_st.
  - Load and swap in the same cycle: the old shadow moves to active and the new beat lands in shadow; shadow_vld stays 1.
- FSM, two states:
  - EMPTY (active_vld=0) and ACTIVE (active_vld=1).
  - in_dat_prdy = stripe_st ? shadow_vld : active_vld. It is combinational on the payload; the upstream holds the payload stable while pvld=1.
  - EMPTY, accept with stripe_st: swap, go to ACTIVE.
  - EMPTY, beat without stripe_st: prdy=0 indefinitely and proto_err set (the upstream must not do this).
  - ACTIVE, accept with stripe_end: go to EMPTY and clear active_vld after issue. stripe_st=stripe_end=1 is a one-beat stripe: swap, issue, go to EMPTY.
  - ACTIVE, stripe_st without a preceding end: implicit end plus new start, swap, set proto_err.
- Issue:
  - Fixed 1-cycle latency: a data beat accepted at cycle N appears on the outputs at N+1.
  - dat_actv_pvld and wt_actv_pvld are {ATOMC{1}} for one cycle per accepted beat; otherwise 0.
  - Data/nz outputs hold their last value when pvld=0 (no toggling).
  - The weight sent with each beat is the active weight after any swap that cycle.
- stripe_beat_cnt:
  - Loads 1 on a stripe_st issue.
  - Increments on each other issue and saturates at all-ones.
  - Holds after stripe_end.
- cfg_reg_en:
  - Synchronous flush: shadow_vld=0, active_vld=0, FSM=EMPTY, proto_err=0, stripe_beat_cnt=0, pvld outputs 0 next cycle.
  - Takes priority over any accept in the same cycle: in_wt_prdy and in_dat_prdy are forced 0 that cycle.
- Widths: no arithmetic on data; the data path is pass-through or masked only.

Optional Feature:
- Macro CMAC_FEEDER_ZERO_GATE_EN.
- Defined:
  - eff_nz[i] = dat_mask[i] & wt_mask_active[i].
  - dat_actv_nz = wt_actv_nz = eff_nz.
  - Lanes with eff_nz[i]=0 drive 0 on both data and weight outputs, for MAC power saving.
- Undefined:
  - Data and weights pass unmodified.
  - dat_actv_nz = dat_mask and wt_actv_nz = active weight mask.

Test Plan:
- Reset, then load weight 0x0807060504030201 with mask 0xFF, then send data 0x0101010101010101 with st=end=1 -> next cycle: pvld=0xFF, wt_actv_data=0x0807060504030201, stripe_beat_cnt=1, FSM back to EMPTY.
- Data beat with st=1 and no weight loaded -> in_dat_prdy=0. Load a weight; data is accepted the same cycle the weight is visible in shadow+1, and output appears 1 cycle later.
- Back-to-back: shadow W1, stripe of 4 beats while W2 loads -> W2 is accepted into shadow during the stripe; beats 1-4 carry W1; stripe_beat_cnt reaches 4; the next stripe_st carries W2.
- Same-cycle swap and load: shadow=W1, accept data with st=1 and wt W2 together -> active=W1, shadow=W2, in_wt_prdy=1 that cycle.
- ACTIVE, stripe_st without end -> proto_err=1 and the beat is issued with the new weight. Then cfg_reg_en -> proto_err=0, both prdy=0 that cycle, pvld=0.
- With CMAC_FEEDER_ZERO_GATE_EN: dat_mask=0xF0, wt_mask=0x3C -> nz=0x30, lanes 0-3 and 6-7 drive 0x00. Without the macro: dat_nz=0xF0, wt_nz=0x3C, data unmodified.
